ksz8851_init_seq: RTL and testbench
===================================

Name: ksz8851_init_seq

Overview:
- Upstream command sequencer for the KSZ8851 bus-cycle layer.
- Each time that layer raises initReq after a chip reset, this block:
  - acknowledges the request;
  - reads and checks the chip ID register;
  - issues a fixed table of 16-bit register writes (MAC address, TX/RX frame pointers, TX/RX control, interrupt enable) over the cmdReq/cmdAck handshake.
- Reports done/error status to the EthernetIO level and gates higher-level traffic until initialisation has succeeded.

Parameters:
- CMD_TIMEOUT, 1024, sysclk cycles allowed per command (cmdReq rise to completion) before timeout error.
- CHIP_ID_EXP, 16'h8870, expected CIDER value after masking.
- CHIP_ID_MASK, 16'hFFF0, mask applied to CIDER read data (ignores revision bits).

Ports:
- sysclk  in  1  system clock (49.152 MHz)
- reset  in  1  synchronous, active-high reset
- mac_addr  in  48  station MAC address; sampled at the initAck cycle
- initReq  in  1  chip-reset-complete request from KSZ8851 layer
- initAck  out  1  one-cycle pulse acknowledging initReq
- cmdReq  out  1  command request to KSZ8851 layer
- cmdAck  in  1  command accepted
- dataValid  in  1  read data valid on DataOut
- ksz_isIdle  in  1  KSZ8851 layer in idle state
- isDMA  out  1  constant 0 (register mode only)
- isWrite  out  1  1=write, 0=read
- isWord  out  1  constant 1 (all accesses 16-bit, even addresses)
- RegAddr  out  8  register offset
- DataIn  out  16  write data to chip
- DataOut  in  16  read data from chip
- init_done  out  1  sequence completed without error
- init_error  out  1  sequence aborted
- error_code  out  3  0=none, 1=chip ID mismatch, 2=timeout, 3=readback mismatch
- chip_id  out  16  last raw CIDER value read
- dbg_state  out  4  current state encoding

Behaviour:
- Reset values: all outputs 0; state ST_IDLE.
- Interface contract: reset is synchronous and active-high (already decided).
- Write table, fixed, index 0..7 as (addr, data):
  - 0: 0x10, mac[15:0]
  - 1: 0x12, mac[31:16]
  - 2: 0x14, mac[47:32]
  - 3: 0x84, 0x4000
  - 4: 0x70, 0x01EE
  - 5: 0x86, 0x4000
  - 6: 0x74, 0x7CE0
  - 7: 0x90, 0xE000
- States:
  - ST_IDLE: wait for initReq=1.
  - ST_ACK: initAck=1 for exactly one cycle; latch mac_addr; clear init_done, init_error, error_code; index=0 -> ST_ID_REQ.
  - ST_ID_REQ: cmdReq=1, isWrite=0, RegAddr=0xC0.
  - ST_ID_WAIT: hold cmdReq until dataValid=1. In the dataValid cycle: capture DataOut into chip_id, drop cmdReq.
  - ST_ID_CHECK: wait ksz_isIdle=1. Then (chip_id & CHIP_ID_MASK)==CHIP_ID_EXP -> ST_WR_REQ, else ST_ERROR code 1.
  - ST_WR_REQ: cmdReq=1, isWrite=1, RegAddr/DataIn from table[index].
  - ST_WR_WAIT: drop cmdReq the cycle after cmdAck=1, then wait ksz_isIdle=1 -> ST_NEXT.
  - ST_NEXT: index==7 -> ST_DONE, else index+1 -> ST_WR_REQ.
  - ST_DONE: init_done=1, held until next initReq or reset.
  - ST_ERROR: init_error=1 and error_code, held until next initReq or reset.
- Handshake rules:
  - RegAddr, isWrite and DataIn are stable from cmdReq rise until cmdReq falls.
  - cmdReq is never raised unless ksz_isIdle=1.
  - Read commands never drop cmdReq before dataValid.
- Timeout:
  - A 16-bit counter clears on entry to each *_REQ state and increments in *_REQ/*_WAIT/ID_CHECK.
  - Reaching CMD_TIMEOUT drops cmdReq -> ST_ERROR code 2.
- Restart: initReq=1 in any state other than ST_IDLE/ST_ACK (chip re-reset mid-sequence):
  - drop cmdReq the same cycle;
  - -> ST_ACK next cycle;
  - counter and index cleared.
- Simultaneous initReq and dataValid/cmdAck: restart wins; data is discarded.
- reset mid-command: all outputs to reset values next edge; cmdReq low.

Optional Feature:
- Macro: KSZ_INIT_READBACK_EN.
- Defined:
  - After each write's ksz_isIdle, states ST_RB_REQ/ST_RB_WAIT read the same address (same read handshake as ST_ID_*).
  - Read data != written data -> ST_ERROR code 3.
  - Otherwise -> ST_NEXT.
  - Timeout applies to readback.
  - Exception: entries 3 and 5 (0x84, 0x86) compare only bit 14.
- Undefined: no readback states; error_code 3 is never produced.

Test Plan:
- Nominal: reset, initReq pulse, model returns CIDER=0x8872, mac=0x0A1B2C3D4E5F -> initAck 1 cycle; 1 read at 0xC0; 8 writes in table order (0x10=0x4E5F, 0x12=0x2C3D, 0x14=0x0A1B, ...); init_done=1; chip_id=0x8872.
- ID mismatch: CIDER=0x1234 -> no writes issued; init_error=1; error_code=1; cmdReq=0.
- Timeout: model never asserts cmdAck on write index 4 -> after 1024 cycles cmdReq=0; error_code=2; init_done=0.
- Restart: initReq re-asserted during write index 2 -> cmdReq falls same cycle; initAck pulses; sequence restarts from CIDER read and completes with init_done=1.
- Handshake: ksz_isIdle forced 0 for 20 cycles after each command -> cmdReq never rises while ksz_isIdle=0; RegAddr/DataIn stable throughout every cmdReq high interval.
- KSZ_INIT_READBACK_EN: model corrupts readback of 0x70 to 0x01EF -> error_code=3 after 5th write; with the macro undefined, the same model gives init_done=1.

Source files
------------

// File: rtl/ksz8851_init_seq.sv
// ksz8851_init_seq: brings the KSZ8851 up after every chip reset.
// On each initReq it acknowledges the request, reads and checks CIDER, then
// writes a fixed 8-entry register table over the cmdReq/cmdAck handshake.
// It reports done/error status and gates traffic until init has succeeded.
// Optional build macro KSZ_INIT_READBACK_EN adds a read-back and compare
// after every table write.
module ksz8851_init_seq #(
  parameter int          CMD_TIMEOUT  = 1024,
  parameter logic [15:0] CHIP_ID_EXP  = 16'h8870,
  parameter logic [15:0] CHIP_ID_MASK = 16'hFFF0
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [47:0] mac_addr,
  input  logic        initReq,
  output logic        initAck,
  output logic        cmdReq,
  input  logic        cmdAck,
  input  logic        dataValid,
  input  logic        ksz_isIdle,
  output logic        isDMA,
  output logic        isWrite,
  output logic        isWord,
  output logic [7:0]  RegAddr,
  output logic [15:0] DataIn,
  input  logic [15:0] DataOut,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic [15:0] chip_id,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ACK      = 4'd1,
    ST_ID_REQ   = 4'd2,
    ST_ID_WAIT  = 4'd3,
    ST_ID_CHECK = 4'd4,
    ST_WR_REQ   = 4'd5,
    ST_WR_WAIT  = 4'd6,
    ST_NEXT     = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERROR    = 4'd9,
    ST_RB_REQ   = 4'd10,
    ST_RB_WAIT  = 4'd11
  } state_t;

  // Last counter value a command may reach before it is declared stuck.
  localparam logic [15:0] TMO_LAST = 16'(CMD_TIMEOUT - 1);

  function automatic logic [7:0] tbl_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h10;
      3'd1:    return 8'h12;
      3'd2:    return 8'h14;
      3'd3:    return 8'h84;
      3'd4:    return 8'h70;
      3'd5:    return 8'h86;
      3'd6:    return 8'h74;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [15:0] tbl_data(input logic [2:0] idx, input logic [47:0] mac);
    case (idx)
      3'd0:    return mac[15:0];
      3'd1:    return mac[31:16];
      3'd2:    return mac[47:32];
      3'd3:    return 16'h4000;
      3'd4:    return 16'h01EE;
      3'd5:    return 16'h4000;
      3'd6:    return 16'h7CE0;
      default: return 16'hE000;
    endcase
  endfunction

`ifdef KSZ_INIT_READBACK_EN
  // The two frame-pointer registers auto-increment their address bits, so
  // only the auto-increment enable (bit 14) is meaningful on read-back.
  function automatic logic rb_match(input logic [2:0] idx, input logic [15:0] rd,
                                    input logic [15:0] wr);
    if (idx == 3'd3 || idx == 3'd5) return rd[14] == wr[14];
    return rd == wr;
  endfunction
`endif

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [47:0] r_mac, w_mac_nxt;
  logic        r_initAck, w_initAck_nxt;
  logic        r_cmdReq, w_cmdReq_nxt;
  logic        r_isWrite, w_isWrite_nxt;
  logic [7:0]  r_RegAddr, w_RegAddr_nxt;
  logic [15:0] r_DataIn, w_DataIn_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;
  logic [2:0]  r_code, w_code_nxt;
  logic [15:0] r_chip_id, w_chip_id_nxt;
  logic        w_run;

  // Next-state and next-output logic; restart beats timeout beats normal flow.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_mac_nxt     = r_mac;
    w_initAck_nxt = 1'b0;
    w_cmdReq_nxt  = r_cmdReq;
    w_isWrite_nxt = r_isWrite;
    w_RegAddr_nxt = r_RegAddr;
    w_DataIn_nxt  = r_DataIn;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;
    w_code_nxt    = r_code;
    w_chip_id_nxt = r_chip_id;
    w_run = r_state inside {ST_ID_REQ, ST_ID_WAIT, ST_ID_CHECK, ST_WR_REQ,
                            ST_WR_WAIT, ST_RB_REQ, ST_RB_WAIT};
    if (w_run) w_cnt_nxt = r_cnt + 16'd1;

    if (initReq && r_state != ST_IDLE && r_state != ST_ACK) begin
      // Chip was re-reset mid-sequence: abandon any command in flight.
      w_state_nxt  = ST_ACK;
      w_cmdReq_nxt = 1'b0;
      w_cnt_nxt    = 16'd0;
      w_idx_nxt    = 3'd0;
    end else if (w_run && r_cnt == TMO_LAST) begin
      w_state_nxt  = ST_ERROR;
      w_cmdReq_nxt = 1'b0;
      w_code_nxt   = 3'd2;
    end else begin
      case (r_state)
        ST_IDLE: if (initReq) w_state_nxt = ST_ACK;
        ST_ACK: begin
          w_mac_nxt   = mac_addr;
          w_idx_nxt   = 3'd0;
          w_state_nxt = ST_ID_REQ;
        end
        ST_ID_REQ: if (ksz_isIdle) begin
          w_cmdReq_nxt  = 1'b1;
          w_isWrite_nxt = 1'b0;
          w_RegAddr_nxt = 8'hC0;
          w_state_nxt   = ST_ID_WAIT;
        end
        ST_ID_WAIT: if (dataValid) begin
          w_chip_id_nxt = DataOut;
          w_cmdReq_nxt  = 1'b0;
          w_state_nxt   = ST_ID_CHECK;
        end
        ST_ID_CHECK: if (ksz_isIdle) begin
          if ((r_chip_id & CHIP_ID_MASK) == CHIP_ID_EXP) begin
            w_state_nxt = ST_WR_REQ;
          end else begin
            w_state_nxt = ST_ERROR;
            w_code_nxt  = 3'd1;
          end
        end
        ST_WR_REQ: if (ksz_isIdle) begin
          w_cmdReq_nxt  = 1'b1;
          w_isWrite_nxt = 1'b1;
          w_RegAddr_nxt = tbl_addr(r_idx);
          w_DataIn_nxt  = tbl_data(r_idx, r_mac);
          w_state_nxt   = ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (r_cmdReq) begin
            if (cmdAck) w_cmdReq_nxt = 1'b0;
          end else if (ksz_isIdle) begin
`ifdef KSZ_INIT_READBACK_EN
            w_state_nxt = ST_RB_REQ;
`else
            w_state_nxt = ST_NEXT;
`endif
          end
        end
`ifdef KSZ_INIT_READBACK_EN
        ST_RB_REQ: if (ksz_isIdle) begin
          w_cmdReq_nxt  = 1'b1;
          w_isWrite_nxt = 1'b0;
          w_state_nxt   = ST_RB_WAIT;
        end
        ST_RB_WAIT: if (dataValid) begin
          w_cmdReq_nxt = 1'b0;
          if (rb_match(r_idx, DataOut, r_DataIn)) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_state_nxt = ST_ERROR;
            w_code_nxt  = 3'd3;
          end
        end
`endif
        ST_NEXT: begin
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = ST_WR_REQ;
          end
        end
        default: ;
      endcase
    end

    // Side effects tied to entering a state, whichever path got us there.
    if (w_state_nxt != r_state) begin
      if (w_state_nxt inside {ST_ID_REQ, ST_WR_REQ, ST_RB_REQ}) w_cnt_nxt = 16'd0;
      if (w_state_nxt == ST_ACK) begin
        w_initAck_nxt = 1'b1;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_code_nxt    = 3'd0;
      end
      if (w_state_nxt == ST_DONE)  w_done_nxt  = 1'b1;
      if (w_state_nxt == ST_ERROR) w_error_nxt = 1'b1;
    end
  end

  // State and registered outputs; reset returns every output to zero.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_cnt     <= 16'd0;
      r_mac     <= 48'd0;
      r_initAck <= 1'b0;
      r_cmdReq  <= 1'b0;
      r_isWrite <= 1'b0;
      r_RegAddr <= 8'd0;
      r_DataIn  <= 16'd0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= 3'd0;
      r_chip_id <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mac     <= w_mac_nxt;
      r_initAck <= w_initAck_nxt;
      r_cmdReq  <= w_cmdReq_nxt;
      r_isWrite <= w_isWrite_nxt;
      r_RegAddr <= w_RegAddr_nxt;
      r_DataIn  <= w_DataIn_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_code    <= w_code_nxt;
      r_chip_id <= w_chip_id_nxt;
    end
  end

  assign initAck    = r_initAck;
  assign cmdReq     = r_cmdReq;
  assign isDMA      = 1'b0;
  assign isWord     = 1'b1;
  assign isWrite    = r_isWrite;
  assign RegAddr    = r_RegAddr;
  assign DataIn     = r_DataIn;
  assign init_done  = r_done;
  assign init_error = r_error;
  assign error_code = r_code;
  assign chip_id    = r_chip_id;
  assign dbg_state  = 4'(r_state);

endmodule

// File: tb/tb_ksz8851_init_seq.sv
// Bench for ksz8851_init_seq: a cycle-level KSZ8851 bus model answers
// commands, and a scoreboard queue holds the command sequence each scenario
// is expected to produce. Honours KSZ_INIT_READBACK_EN like the design.
module tb_ksz8851_init_seq;

  logic        sysclk;
  logic        reset;
  logic [47:0] mac_addr;
  logic        initReq;
  logic        initAck;
  logic        cmdReq;
  logic        cmdAck;
  logic        dataValid;
  logic        ksz_isIdle;
  logic        isDMA;
  logic        isWrite;
  logic        isWord;
  logic [7:0]  RegAddr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        init_done;
  logic        init_error;
  logic [2:0]  error_code;
  logic [15:0] chip_id;
  logic [3:0]  dbg_state;

  ksz8851_init_seq dut (
    .sysclk(sysclk), .reset(reset), .mac_addr(mac_addr), .initReq(initReq),
    .initAck(initAck), .cmdReq(cmdReq), .cmdAck(cmdAck), .dataValid(dataValid),
    .ksz_isIdle(ksz_isIdle), .isDMA(isDMA), .isWrite(isWrite), .isWord(isWord),
    .RegAddr(RegAddr), .DataIn(DataIn), .DataOut(DataOut), .init_done(init_done),
    .init_error(init_error), .error_code(error_code), .chip_id(chip_id),
    .dbg_state(dbg_state)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

`ifdef KSZ_INIT_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [15:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;

  // Bus model configuration, set by each scenario.
  logic [15:0] cfg_cider;
  int          cfg_hang;
  int          cfg_restart;
  int          cfg_hold;
  bit          cfg_corrupt;

  // Per-run observations.
  int res_acks;
  bit res_ack_wide;
  int res_hang_len;
  bit res_finished;

  function automatic logic [7:0] tb_addr(input int i);
    case (i)
      0: return 8'h10;  1: return 8'h12;  2: return 8'h14;  3: return 8'h84;
      4: return 8'h70;  5: return 8'h86;  6: return 8'h74;  default: return 8'h90;
    endcase
  endfunction

  function automatic logic [15:0] tb_data(input int i);
    case (i)
      0: return mac_addr[15:0];  1: return mac_addr[31:16];  2: return mac_addr[47:32];
      3: return 16'h4000;        4: return 16'h01EE;         5: return 16'h4000;
      6: return 16'h7CE0;        default: return 16'hE000;
    endcase
  endfunction

  // What the chip returns on a read-back of a written register.
  function automatic logic [15:0] rb_value(input logic [7:0] a);
    if (cfg_corrupt && a == 8'h70) return 16'h01EF;
    if (a == 8'h84 || a == 8'h86) return mem[a] ^ 16'h0001;
    return mem[a];
  endfunction

  task automatic push_rd(input logic [7:0] a);
    cmd_t t;
    t.wr = 1'b0; t.addr = a; t.data = 16'h0;
    exp_q.push_back(t);
  endtask

  task automatic push_wr(input int i, input bit rb);
    cmd_t t;
    t.wr = 1'b1; t.addr = tb_addr(i); t.data = tb_data(i);
    exp_q.push_back(t);
    if (rb && RB_EN) begin
      t.wr = 1'b0; t.data = 16'h0;
      exp_q.push_back(t);
    end
  endtask

  task automatic set_cfg(input logic [15:0] cider, input int hang, input int rst_at,
                         input int hold, input bit corrupt);
    cfg_cider = cider; cfg_hang = hang; cfg_restart = rst_at;
    cfg_hold = hold; cfg_corrupt = corrupt;
    exp_q.delete();
  endtask

  // Bus model plus scoreboard; runs until the DUT reports done/error.
  task automatic run_bus(input int max_cyc);
    bit          prev_req, stable_ok, restarted, rs_pend, prev_ack, hung, new_cmd;
    int          busy, wr_idx, req_len;
    logic        lat_wr;
    logic [7:0]  lat_addr;
    logic [15:0] lat_data;
    cmd_t        c, e;
    prev_req = 0; stable_ok = 1; restarted = 0; rs_pend = 0; prev_ack = 0; hung = 0;
    busy = 0; wr_idx = 0; req_len = 0;
    lat_wr = 0; lat_addr = 0; lat_data = 0;
    res_acks = 0; res_ack_wide = 0; res_hang_len = 0; res_finished = 0;
    ksz_isIdle = 1'b1; cmdAck = 1'b0; dataValid = 1'b0; DataOut = 16'h0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge sysclk);
      initReq = 1'b0; cmdAck = 1'b0; dataValid = 1'b0; new_cmd = 0;
      if (initAck === 1'b1) begin
        res_acks++;
        if (prev_ack) res_ack_wide = 1;
      end
      prev_ack = (initAck === 1'b1);
      if (rs_pend) begin
        rs_pend = 0;
        checks++;
        if (cmdReq !== 1'b0 || initAck !== 1'b1) begin
          errors++;
          $display("FAIL restart_drop: cmdReq=%b initAck=%b, required cmdReq=0 initAck=1",
                   cmdReq, initAck);
        end
      end
      if (cmdReq === 1'b1 && !prev_req) begin
        checks++;
        if (ksz_isIdle !== 1'b1) begin
          errors++;
          $display("FAIL req_while_busy: cmdReq rose with ksz_isIdle=%b, required 1", ksz_isIdle);
        end
        lat_wr = isWrite; lat_addr = RegAddr; lat_data = DataIn;
        stable_ok = 1; req_len = 1; new_cmd = 1;
        c.wr = isWrite; c.addr = RegAddr; c.data = isWrite ? DataIn : 16'h0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: got wr/addr/data=%h, required no command", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            errors++;
            $display("FAIL cmd_order: got wr/addr/data=%h, required %h", c, e);
          end
        end
      end else if (cmdReq === 1'b1) begin
        req_len++;
        if (RegAddr !== lat_addr || DataIn !== lat_data || isWrite !== lat_wr) stable_ok = 0;
      end else if (prev_req) begin
        checks++;
        if (!stable_ok) begin
          errors++;
          $display("FAIL cmd_stable: addr/data/dir changed while cmdReq high, got %b required 1",
                   stable_ok);
        end
        if (hung && res_hang_len == 0) res_hang_len = req_len;
      end
      prev_req = (cmdReq === 1'b1);
      if (busy > 0) begin
        busy--;
        if (busy == 0) ksz_isIdle = 1'b1;
      end
      if (new_cmd) begin
        if (!lat_wr && lat_addr == 8'hC0) wr_idx = 0;
        if (lat_wr && wr_idx == cfg_restart && !restarted) begin
          initReq = 1'b1; cmdAck = 1'b1; restarted = 1; rs_pend = 1;
        end else if (lat_wr && wr_idx == cfg_hang) begin
          hung = 1;
        end else begin
          cmdAck = 1'b1; ksz_isIdle = 1'b0; busy = cfg_hold;
          if (lat_wr) mem[lat_addr] = lat_data;
          else begin
            dataValid = 1'b1;
            DataOut = (lat_addr == 8'hC0) ? cfg_cider : rb_value(lat_addr);
          end
        end
        if (lat_wr) wr_idx++;
      end
      if ((init_done === 1'b1 || init_error === 1'b1) && cmdReq === 1'b0 && !rs_pend) begin
        res_finished = 1;
        break;
      end
    end
    checks++;
    if (!res_finished) begin
      errors++;
      $display("FAIL run_timeout: finished=%b after %0d cycles, required 1", res_finished, max_cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    checks++;
    if ({cmdReq, initAck, init_done, init_error, isWrite, isDMA} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {cmdReq, initAck, init_done, init_error, isWrite, isDMA});
    end
    checks++;
    if (error_code !== 3'd0) begin
      errors++; $display("FAIL reset_code: got %0d, required 0", error_code);
    end
    checks++;
    if (chip_id !== 16'h0) begin
      errors++; $display("FAIL reset_chip_id: got %h, required 0000", chip_id);
    end
    checks++;
    if (dbg_state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    checks++;
    if (RegAddr !== 8'h0 || DataIn !== 16'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h, required 00/0000", RegAddr, DataIn);
    end
    reset = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_nominal;
    mac_addr = 48'h0A1B2C3D4E5F;
    set_cfg(16'h8872, -1, -1, 2, 0);
    push_rd(8'hC0);
    for (int i = 0; i < 8; i++) push_wr(i, 1);
    @(negedge sysclk); initReq = 1'b1;
    run_bus(5000);
    checks++;
    if (init_done !== 1'b1 || init_error !== 1'b0 || error_code !== 3'd0) begin
      errors++;
      $display("FAIL nominal_status: done/err/code=%b/%b/%0d, required 1/0/0",
               init_done, init_error, error_code);
    end
    checks++;
    if (chip_id !== 16'h8872) begin
      errors++; $display("FAIL nominal_chip_id: got %h, required 8872", chip_id);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL nominal_missing: %0d commands never issued, required 0", exp_q.size());
    end
    checks++;
    if (res_acks != 1 || res_ack_wide) begin
      errors++;
      $display("FAIL nominal_initAck: %0d cycles high (wide=%b), required 1", res_acks, res_ack_wide);
    end
  endtask

  task automatic test_id_mismatch;
    set_cfg(16'h1234, -1, -1, 2, 0);
    push_rd(8'hC0);
    @(negedge sysclk); initReq = 1'b1;
    run_bus(5000);
    checks++;
    if (init_error !== 1'b1 || error_code !== 3'd1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL idmis_status: err/code/done=%b/%0d/%b, required 1/1/0",
               init_error, error_code, init_done);
    end
    checks++;
    if (cmdReq !== 1'b0 || chip_id !== 16'h1234) begin
      errors++;
      $display("FAIL idmis_bus: cmdReq=%b chip_id=%h, required 0/1234", cmdReq, chip_id);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL idmis_missing: %0d commands never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    set_cfg(16'h8872, 4, -1, 2, 0);
    push_rd(8'hC0);
    for (int i = 0; i < 4; i++) push_wr(i, 1);
    push_wr(4, 0);
    @(negedge sysclk); initReq = 1'b1;
    run_bus(5000);
    checks++;
    if (init_error !== 1'b1 || error_code !== 3'd2 || init_done !== 1'b0 || cmdReq !== 1'b0) begin
      errors++;
      $display("FAIL tmo_status: err/code/done/req=%b/%0d/%b/%b, required 1/2/0/0",
               init_error, error_code, init_done, cmdReq);
    end
    checks++;
    if (res_hang_len < 1000 || res_hang_len > 1030) begin
      errors++; $display("FAIL tmo_length: cmdReq high %0d cycles, required about 1024", res_hang_len);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL tmo_missing: %0d commands never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_restart;
    set_cfg(16'h8872, -1, 2, 2, 0);
    push_rd(8'hC0);
    push_wr(0, 1); push_wr(1, 1); push_wr(2, 0);
    push_rd(8'hC0);
    for (int i = 0; i < 8; i++) push_wr(i, 1);
    @(negedge sysclk); initReq = 1'b1;
    run_bus(5000);
    checks++;
    if (init_done !== 1'b1 || init_error !== 1'b0) begin
      errors++;
      $display("FAIL restart_status: done/err=%b/%b, required 1/0", init_done, init_error);
    end
    checks++;
    if (res_acks != 2 || res_ack_wide) begin
      errors++;
      $display("FAIL restart_acks: %0d initAck cycles (wide=%b), required 2", res_acks, res_ack_wide);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL restart_missing: %0d commands never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_handshake;
    mac_addr = 48'h123456789ABC;
    set_cfg(16'h887F, -1, -1, 20, 0);
    push_rd(8'hC0);
    for (int i = 0; i < 8; i++) push_wr(i, 1);
    @(negedge sysclk); initReq = 1'b1;
    run_bus(8000);
    checks++;
    if (init_done !== 1'b1 || chip_id !== 16'h887F) begin
      errors++;
      $display("FAIL hs_status: done=%b chip_id=%h, required 1/887F", init_done, chip_id);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL hs_missing: %0d commands never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_readback;
    logic       exp_done;
    logic [2:0] exp_code;
    set_cfg(16'h8872, -1, -1, 2, 1);
    push_rd(8'hC0);
`ifdef KSZ_INIT_READBACK_EN
    for (int i = 0; i < 5; i++) push_wr(i, 1);
    exp_done = 1'b0; exp_code = 3'd3;
`else
    for (int i = 0; i < 8; i++) push_wr(i, 1);
    exp_done = 1'b1; exp_code = 3'd0;
`endif
    @(negedge sysclk); initReq = 1'b1;
    run_bus(5000);
    checks++;
    if (init_done !== exp_done || error_code !== exp_code || init_error !== ~exp_done) begin
      errors++;
      $display("FAIL rb_status: done/code/err=%b/%0d/%b, required %b/%0d/%b",
               init_done, error_code, init_error, exp_done, exp_code, ~exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rb_missing: %0d commands never issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    ksz_isIdle = 1'b1; cmdAck = 1'b0; dataValid = 1'b0;
    @(negedge sysclk); initReq = 1'b1;
    @(negedge sysclk); initReq = 1'b0;
    for (int i = 0; i < 10 && cmdReq !== 1'b1; i++) @(negedge sysclk);
    checks++;
    if (cmdReq !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup: cmdReq=%b, required 1", cmdReq);
    end
    reset = 1'b1;
    @(negedge sysclk);
    checks++;
    if (cmdReq !== 1'b0 || dbg_state !== 4'd0 || init_done !== 1'b0 || RegAddr !== 8'h0) begin
      errors++;
      $display("FAIL rstmid_clear: req/state/done/addr=%b/%0d/%b/%h, required 0/0/0/00",
               cmdReq, dbg_state, init_done, RegAddr);
    end
    reset = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    reset = 1'b1; initReq = 1'b0; cmdAck = 1'b0; dataValid = 1'b0;
    ksz_isIdle = 1'b1; DataOut = 16'h0; mac_addr = 48'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    set_cfg(16'h8872, -1, -1, 2, 0);
    test_reset();
    test_nominal();
    test_id_mismatch();
    test_timeout();
    test_restart();
    test_handshake();
    test_readback();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
